// File: rtl/pc_stack_unit.sv
// -----------------------------------------------------------------------------
// pc_stack_unit
//
// Program counter for the hera core with an internal return-address stack.
// Each cycle the next fetch address (npc) is chosen combinationally from
// reset vector, hold, return (stack pop), call (stack push), taken branch
// or sequential increment. The PC register captures npc on every edge, so
// ROM sees npc with zero latency and the ALU sees pc one cycle later.
//
// Ports:
//   clk          core clock
//   rst          synchronous reset, active-high
//   hold_pc      stall: freeze PC and stack, ignore all other requests
//   taken_pc     branch taken (from ALU)
//   next_pc      branch/call target (from ALU); bits above ADDR_W ignored
//   call_pc      call: push return address, jump to next_pc
//   return_pc    return: pop stack, jump to popped address
//   npc          combinational fetch address to ROM
//   pc           registered current PC to ALU
//   stack_empty  registered, sp == 0
//   stack_full   registered, sp == DEPTH
//   stack_err    registered sticky overflow/underflow flag, cleared by rst
// -----------------------------------------------------------------------------
module pc_stack_unit #(
    parameter int              PC_W      = 16,
    parameter int              ADDR_W    = 10,
    parameter int              DEPTH     = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold_pc,
    input  logic              taken_pc,
    input  logic [PC_W-1:0]   next_pc,
    input  logic              call_pc,
    input  logic              return_pc,
    output logic [ADDR_W-1:0] npc,
    output logic [PC_W-1:0]   pc,
    output logic              stack_empty,
    output logic              stack_full,
    output logic              stack_err
);

    // sp counts occupied entries 0..DEPTH, so it needs one more value than
    // the entry index range.
    localparam int SP_W  = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    logic [PC_W-1:0]   pc_reg;
    logic [SP_W-1:0]   sp_reg;
    logic [SP_W-1:0]   sp_next;
    logic              empty_reg;
    logic              full_reg;
    logic              err_reg;
    logic              err_next;

    logic [ADDR_W-1:0] stack_mem [DEPTH];

    logic [ADDR_W-1:0] inc;
    logic [ADDR_W-1:0] target;
    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  wr_idx;
    logic [ADDR_W-1:0] top_addr;
    logic              do_push;

    assign inc      = pc_reg[ADDR_W-1:0] + 1'b1;  // wraps modulo 2^ADDR_W
    assign target   = next_pc[ADDR_W-1:0];
    // Indices are only used when the pointer is in range (pop when non-empty,
    // push when non-full), so truncation is safe.
    assign rd_idx   = IDX_W'(sp_reg - 1'b1);
    assign wr_idx   = IDX_W'(sp_reg);
    assign top_addr = stack_mem[rd_idx];

    // Next-address selection and stack control, first match wins.
    // Only registered state (pc_reg, sp_reg, flags) feeds this block, so
    // there is no loop through npc.
    always_comb begin
        npc      = inc;
        sp_next  = sp_reg;
        err_next = err_reg;
        do_push  = 1'b0;
        if (rst) begin
            npc      = RESET_VEC;
            sp_next  = '0;
            err_next = 1'b0;
        end else if (hold_pc) begin
            npc = pc_reg[ADDR_W-1:0];
        end else if (return_pc) begin
            if (!empty_reg) begin
                npc     = top_addr;
                sp_next = sp_reg - 1'b1;
            end else begin
                npc      = inc;
                err_next = 1'b1;
            end
        end else if (call_pc) begin
            npc = target;
            if (!full_reg) begin
                do_push = 1'b1;
                sp_next = sp_reg + 1'b1;
            end else begin
                err_next = 1'b1;
            end
        end else if (taken_pc) begin
            npc = target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg    <= PC_W'(RESET_VEC);
            sp_reg    <= '0;
            empty_reg <= 1'b1;
            full_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            pc_reg    <= PC_W'(npc);
            sp_reg    <= sp_next;
            empty_reg <= (sp_next == '0);
            full_reg  <= (sp_next == SP_W'(DEPTH));
            err_reg   <= err_next;
        end
    end

    // Stack storage has no reset; contents survive rst and are only
    // meaningful below sp. do_push is already suppressed during rst.
    always_ff @(posedge clk) begin
        if (do_push) begin
            stack_mem[wr_idx] <= inc;
        end
    end

    assign pc          = pc_reg;
    assign stack_empty = empty_reg;
    assign stack_full  = full_reg;
    assign stack_err   = err_reg;

endmodule

// File: tb/tb_pc_stack_unit.sv
module tb_pc_stack_unit;

    localparam int PC_W   = 16;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              hold_pc;
    logic              taken_pc;
    logic [PC_W-1:0]   next_pc;
    logic              call_pc;
    logic              return_pc;
    logic [ADDR_W-1:0] npc;
    logic [PC_W-1:0]   pc;
    logic              stack_empty;
    logic              stack_full;
    logic              stack_err;

    int tests = 0;
    int fails = 0;

    pc_stack_unit #(
        .PC_W(PC_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_VEC(10'd0)
    ) dut (
        .clk(clk), .rst(rst), .hold_pc(hold_pc), .taken_pc(taken_pc),
        .next_pc(next_pc), .call_pc(call_pc), .return_pc(return_pc),
        .npc(npc), .pc(pc), .stack_empty(stack_empty),
        .stack_full(stack_full), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("[TB] %s obs=%0h exp=%0h", tag, obs, exp);
    endtask

    // Advance one clock; inputs and checks happen 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; hold_pc = 1'b0; taken_pc = 1'b0; next_pc = '0;
        call_pc = 1'b0; return_pc = 1'b0;

        // Reset, then sequential run
        step(); step();
        check("rst_npc", 32'(npc), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_empty", 32'(stack_empty), 32'd1);
        check("rst_full", 32'(stack_full), 32'd0);
        check("rst_err", 32'(stack_err), 32'd0);
        rst = 1'b0;
        #1;
        check("seq_npc0", 32'(npc), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            step();
            check("seq_pc", 32'(pc), 32'(i));
            check("seq_npc", 32'(npc), 32'(i + 1));
        end
        check("seq_empty", 32'(stack_empty), 32'd1);

        // Branch and wrap (upper next_pc bits must be ignored)
        step(); step();
        check("br_pc5", 32'(pc), 32'd5);
        taken_pc = 1'b1; next_pc = 16'hA3FF;
        #1;
        check("br_npc", 32'(npc), 32'h3FF);
        step();
        taken_pc = 1'b0;
        #1;
        check("br_pc", 32'(pc), 32'h03FF);
        check("wrap_npc", 32'(npc), 32'h000);
        step();
        check("wrap_pc", 32'(pc), 32'h0000);

        // Call/return pair
        for (int i = 0; i < 10; i++) step();
        check("call_at", 32'(pc), 32'd10);
        call_pc = 1'b1; next_pc = 16'd100;
        #1;
        check("call_npc", 32'(npc), 32'd100);
        step();
        call_pc = 1'b0;
        check("call_pc", 32'(pc), 32'd100);
        check("call_empty", 32'(stack_empty), 32'd0);
        step(); step(); step();
        check("run_pc", 32'(pc), 32'd103);
        return_pc = 1'b1;
        #1;
        check("ret_npc", 32'(npc), 32'd11);
        step();
        return_pc = 1'b0;
        check("ret_pc", 32'(pc), 32'd11);
        check("ret_empty", 32'(stack_empty), 32'd1);

        // Overflow: 5 nested calls, pushes 12,201,301,401
        call_pc = 1'b1;
        next_pc = 16'd200; step(); check("ov_pc1", 32'(pc), 32'd200);
        next_pc = 16'd300; step(); check("ov_pc2", 32'(pc), 32'd300);
        next_pc = 16'd400; step(); check("ov_pc3", 32'(pc), 32'd400);
        check("ov_full3", 32'(stack_full), 32'd0);
        next_pc = 16'd500; step(); check("ov_pc4", 32'(pc), 32'd500);
        check("ov_full4", 32'(stack_full), 32'd1);
        check("ov_err4", 32'(stack_err), 32'd0);
        next_pc = 16'd600; step(); check("ov_pc5", 32'(pc), 32'd600);
        check("ov_err5", 32'(stack_err), 32'd1);
        call_pc = 1'b0; taken_pc = 1'b1; return_pc = 1'b1;  // return wins
        #1;
        check("pop1_npc", 32'(npc), 32'd401);
        step(); check("pop1_pc", 32'(pc), 32'd401);
        taken_pc = 1'b0;
        check("pop1_full", 32'(stack_full), 32'd0);
        step(); check("pop2_pc", 32'(pc), 32'd301);
        step(); check("pop3_pc", 32'(pc), 32'd201);
        step(); check("pop4_pc", 32'(pc), 32'd12);
        return_pc = 1'b0;
        check("pop_empty", 32'(stack_empty), 32'd1);

        // Underflow (after reset clears the sticky flag)
        rst = 1'b1; step(); rst = 1'b0;
        check("uf_rst_err", 32'(stack_err), 32'd0);
        return_pc = 1'b1;
        #1;
        check("uf_npc", 32'(npc), 32'd1);
        step();
        return_pc = 1'b0;
        check("uf_pc", 32'(pc), 32'd1);
        check("uf_err", 32'(stack_err), 32'd1);

        // Hold together with call
        hold_pc = 1'b1; call_pc = 1'b1; next_pc = 16'd50;
        #1;
        check("hold_npc", 32'(npc), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_pc", 32'(pc), 32'd1);
            check("hold_empty", 32'(stack_empty), 32'd1);
        end
        hold_pc = 1'b0;
        step();
        call_pc = 1'b0;
        check("unhold_pc", 32'(pc), 32'd50);
        check("unhold_empty", 32'(stack_empty), 32'd0);

        // Reset mid-call with sp=2
        rst = 1'b1; step(); rst = 1'b0;
        call_pc = 1'b1;
        next_pc = 16'd20; step();
        next_pc = 16'd30; step();
        check("mid_pc", 32'(pc), 32'd30);
        rst = 1'b1; next_pc = 16'd40;
        #1;
        check("mid_npc", 32'(npc), 32'd0);
        step();
        rst = 1'b0; call_pc = 1'b0;
        check("mid_pc_rst", 32'(pc), 32'd0);
        check("mid_empty", 32'(stack_empty), 32'd1);
        check("mid_full", 32'(stack_full), 32'd0);
        check("mid_err", 32'(stack_err), 32'd0);
        return_pc = 1'b1;
        #1;
        check("mid_nopop_npc", 32'(npc), 32'd1);
        step();
        return_pc = 1'b0;
        check("mid_nopop_err", 32'(stack_err), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
